// File: rtl/vga_timing_gen.sv
// Pixel/line timing generator: h/v counters with registered sync and display-enable decode.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_DISPLAY  = 400,
  parameter int V_FP       = 12,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 35,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 1,
  parameter int H_W        = 10,
  parameter int V_W        = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_en,
  input  logic           restart,
  output logic [H_W-1:0] h_count,
  output logic [V_W-1:0] v_count,
  output logic           hsync,
  output logic           vsync,
  output logic           display_en,
  output logic           line_end,
  output logic           frame_end
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]    frame_count
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_MAX = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_MAX = V_W'(V_TOTAL - 1);

  // Bounds are one bit wider so an end value equal to 2^W does not alias to zero.
  localparam logic [H_W:0] H_DISP_END   = (H_W+1)'(H_DISPLAY);
  localparam logic [H_W:0] H_SYNC_START = (H_W+1)'(H_DISPLAY + H_FP);
  localparam logic [H_W:0] H_SYNC_STOP  = (H_W+1)'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [V_W:0] V_DISP_END   = (V_W+1)'(V_DISPLAY);
  localparam logic [V_W:0] V_SYNC_START = (V_W+1)'(V_DISPLAY + V_FP);
  localparam logic [V_W:0] V_SYNC_STOP  = (V_W+1)'(V_DISPLAY + V_FP + V_SYNC);

  localparam logic H_ACTIVE = 1'(H_SYNC_POL);
  localparam logic V_ACTIVE = 1'(V_SYNC_POL);

  logic [H_W-1:0] h_count_reg, h_count_next;
  logic [V_W-1:0] v_count_reg, v_count_next;
  logic           hsync_reg, hsync_next;
  logic           vsync_reg, vsync_next;
  logic           display_en_reg, display_en_next;
  logic           h_last, v_last;
  logic [H_W:0]   h_ext;
  logic [V_W:0]   v_ext;

  assign h_last = (h_count_reg == H_MAX);
  assign v_last = (v_count_reg == V_MAX);

  always_comb begin
    h_count_next = h_count_reg;
    v_count_next = v_count_reg;
    if (restart) begin
      h_count_next = '0;
      v_count_next = '0;
    end else if (pix_en) begin
      h_count_next = h_last ? '0 : h_count_reg + 1'b1;
      if (h_last) begin
        v_count_next = v_last ? '0 : v_count_reg + 1'b1;
      end
    end
  end

  // Decode from the next-state counts so the registered flags line up with the counts.
  always_comb begin
    h_ext           = {1'b0, h_count_next};
    v_ext           = {1'b0, v_count_next};
    hsync_next      = ((h_ext >= H_SYNC_START) && (h_ext < H_SYNC_STOP)) ? H_ACTIVE : ~H_ACTIVE;
    vsync_next      = ((v_ext >= V_SYNC_START) && (v_ext < V_SYNC_STOP)) ? V_ACTIVE : ~V_ACTIVE;
    display_en_next = (h_ext < H_DISP_END) && (v_ext < V_DISP_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_count_reg    <= '0;
      v_count_reg    <= '0;
      hsync_reg      <= ~H_ACTIVE;
      vsync_reg      <= ~V_ACTIVE;
      display_en_reg <= 1'b1;
    end else begin
      h_count_reg    <= h_count_next;
      v_count_reg    <= v_count_next;
      hsync_reg      <= hsync_next;
      vsync_reg      <= vsync_next;
      display_en_reg <= display_en_next;
    end
  end

  assign h_count    = h_count_reg;
  assign v_count    = v_count_reg;
  assign hsync      = hsync_reg;
  assign vsync      = vsync_reg;
  assign display_en = display_en_reg;
  assign line_end   = pix_en & h_last;
  assign frame_end  = line_end & v_last;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count_reg;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      frame_count_reg <= '0;
    end else if (frame_end) begin
      frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign frame_count = frame_count_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced mode so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HD = 10, HFP = 2, HS = 3, HBP = 2;
  localparam int VD = 6,  VFP = 2, VS = 2, VBP = 3;
  localparam int HSP = 0, VSP = 1;
  localparam int HW = 5, VW = 4;
  localparam int HT = HD + HFP + HS + HBP;
  localparam int VT = VD + VFP + VS + VBP;
  localparam int TOTAL = HT * VT;

  logic          clk = 1'b0;
  logic          reset, pix_en, restart;
  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          hsync, vsync, display_en, line_end, frame_end;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_SYNC_POL(HSP), .V_SYNC_POL(VSP), .H_W(HW), .V_W(VW)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .restart(restart),
    .h_count(h_count), .v_count(v_count), .hsync(hsync), .vsync(vsync),
    .display_en(display_en), .line_end(line_end), .frame_end(frame_end)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(frame_count)
`endif
  );

  typedef struct {
    int h; int v; bit hs; bit vs; bit de; bit le; bit fe; int fc;
  } exp_t;

  exp_t sb[$];
  int   pos = 0;        // enabled cycles since last reset/restart, modulo TOTAL
  int   fc_model = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   drv_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One cycle of stimulus: push what the DUT must show this cycle, then advance the model.
  task automatic drive(input bit rst, input bit rs, input bit en);
    exp_t e;
    bit   h_act, v_act;
    @(posedge clk); #1;
    reset = rst; restart = rs; pix_en = en;
    e.h   = pos % HT;
    e.v   = pos / HT;
    h_act = (e.h >= HD + HFP) && (e.h < HD + HFP + HS);
    v_act = (e.v >= VD + VFP) && (e.v < VD + VFP + VS);
    e.hs  = h_act ? 1'(HSP) : !1'(HSP);
    e.vs  = v_act ? 1'(VSP) : !1'(VSP);
    e.de  = (e.h < HD) && (e.v < VD);
    e.le  = en && (e.h == HT - 1);
    e.fe  = e.le && (e.v == VT - 1);
    e.fc  = fc_model;
    sb.push_back(e);
    if (rst || rs) begin
      pos = 0;
      fc_model = 0;
    end else if (en) begin
      if (e.fe) fc_model = (fc_model + 1) % 65536;
      pos = (pos + 1) % TOTAL;
    end
  endtask

  task automatic run_to(input int target);
    while (pos != target) drive(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("h_count",    32'(h_count),    e.h);
        check("v_count",    32'(v_count),    e.v);
        check("hsync",      32'(hsync),      int'(e.hs));
        check("vsync",      32'(vsync),      int'(e.vs));
        check("display_en", 32'(display_en), int'(e.de));
        check("line_end",   32'(line_end),   int'(e.le));
        check("frame_end",  32'(frame_end),  int'(e.fe));
`ifdef VGA_FRAME_CNT_EN
        check("frame_count", 32'(frame_count), e.fc);
`endif
        $display("txn rst=%0b rs=%0b en=%0b h=%0d v=%0d hs=%0b vs=%0b de=%0b le=%0b fe=%0b",
                 reset, restart, pix_en, h_count, v_count, hsync, vsync,
                 display_en, line_end, frame_end);
      end
    end
  end

  initial begin
    reset = 1'b1; restart = 1'b0; pix_en = 1'b0;
    repeat (2) @(posedge clk);
    pos = 0;
    fc_model = 0;

    // Reset held with pix_en high, then a full frame plus a line.
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < TOTAL + HT; i++) drive(1'b0, 1'b0, 1'b1);

    // pix_en toggled around the last pixel of the frame.
    run_to(TOTAL - 2);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);

    // Restart mid-frame with and without pix_en, then reset together with restart.
    run_to(4 * HT + 5);
    drive(1'b0, 1'b1, 1'b1);
    run_to(4 * HT + 5);
    drive(1'b0, 1'b1, 1'b0);
    run_to(4 * HT + 5);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);

    // Three frames then restart (frame counter 3 then 0 when present).
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3 * TOTAL; i++) drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    // Randomised enable/restart/reset mix.
    for (int i = 0; i < 2500; i++) begin
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 3) != 0);
    end
    drv_done = 1'b1;
  end

  initial begin
    int budget;
    wait (drv_done);
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
